watch_dp: RTL and testbench
===========================

# watch_dp

Timekeeping datapath for the digital watch, directly downstream of the watch control unit. It keeps hours, minutes, seconds and hundredths from a clock-derived 10 ms tick. It applies the control unit's single-cycle increment/decrement pulses to the field chosen by the 2-bit position select. Its outputs feed the FND/display formatter.

## Interface
- `TICK_DIV`, default 1_000_000: clk cycles per 10 ms tick (100 MHz clk); minimum 2.
- `HOUR_INIT`, default 12: hour value loaded on reset; must be 0..23.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset. Synchronous and active-high.
- `sel_pos` input 2: field select from control unit.
  - 0 = seconds, 1 = minutes, 2 = hours, 3 = none.
- `i_inc` input 1: one-cycle increment pulse for the selected field.
- `i_dec` input 1: one-cycle decrement pulse for the selected field.
- `o_csec` output 7: hundredths, 0..99.
- `o_sec` output 6: seconds, 0..59.
- `o_min` output 6: minutes, 0..59.
- `o_hour` output 5: hours, 0..23.
- `o_tick` output 1: one-cycle pulse in the cycle after a tick is applied to the time fields.

## Operation
- Prescaler `div_cnt` counts 0..TICK_DIV-1 and wraps. A tick event is raised in any cycle where `div_cnt == TICK_DIV-1`.
- Tick advance: csec+1.
  - csec 99→0 carries to sec. Sec 59→0 carries to min. Min 59→0 carries to hour. Hour 23→0.
- Adjust event: exactly one of `i_inc`/`i_dec` is high and `sel_pos` ≠ 3.
  - `i_inc` and `i_dec` both high: no adjust and no change.
  - `sel_pos` = 3: pulses are ignored.
- Adjust touches only the selected field. It wraps within the field's range:
  - sec/min: 59 inc→0, 0 dec→59.
  - hour: 23 inc→0, 0 dec→23.
  - Adjusts never modify csec or `div_cnt`.
- Tick/adjust collision: if an adjust event and a tick event (or an already pending tick) occur in the same cycle:
  - The adjust is applied and the tick is latched into `tick_pending`.
  - The pending tick is applied in the first following cycle with no adjust event, then `tick_pending` is cleared.
  - Only one tick can be pending. If a second tick arrives while one is pending, the second is dropped. This cannot happen while TICK_DIV ≥ 2 and adjusts are single-cycle pulses.
- `o_tick` is registered. It is high for one cycle after any cycle in which a tick (fresh or pending) was applied.

## Timing
- Reset values, all visible the cycle after `rst` is sampled high:
  - `div_cnt` 0, `tick_pending` 0.
  - `o_csec` 0, `o_sec` 0, `o_min` 0, `o_hour` HOUR_INIT, `o_tick` 0.
- Reset has priority over everything. A reset mid-tick or mid-adjust discards the event and any pending tick.
- Adjust latency: pulse sampled at edge N; field value updated and visible from cycle N+1.
- Tick latency: `div_cnt == TICK_DIV-1` at edge N; csec (and any carries) updated at N+1; `o_tick` high during N+1.
- First tick after reset arrives TICK_DIV cycles after reset is released.
- A deferred tick is applied exactly one cycle late per consecutive adjust cycle. No ticks are lost in normal operation.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `WATCH_ADJ_CARRY_EN` defined: adjusts propagate carry and borrow to higher fields.
  - sec inc 59→0 increments min. sec dec 0→59 decrements min.
  - min likewise into hour. Hour still wraps 23↔0.
- `WATCH_ADJ_CARRY_EN` undefined: adjusts wrap within the selected field only, as described above.
- Tick advance always carries, regardless of the macro.

## Test plan
- Reset state: assert `rst` for 2 cycles with `HOUR_INIT`=12, `TICK_DIV`=4.
  - Outputs read 12:00:00.00 and `o_tick`=0.
  - First `o_tick` appears 4 cycles after release.
- Full rollover: preload via adjust to 23:59:59, then run to csec 99 and one more tick.
  - Outputs read 00:00:00.00 and `o_tick`=1 in that cycle.
- Field adjust wrap:
  - `sel_pos`=1, min=59, `i_inc` pulse → min=0. Without macro hour is unchanged; with macro hour+1.
  - `sel_pos`=0, sec=0, `i_dec` → sec=59. Without macro min is unchanged; with macro min-1.
- Ignored adjusts:
  - `sel_pos`=3 with `i_inc` → no change.
  - `i_inc`=`i_dec`=1 with `sel_pos`=2 → hour unchanged.
- Collision: `i_inc` on sec in the same cycle as a tick with csec=99, sec=10.
  - Next cycle: sec=11, csec=99, `o_tick`=0.
  - Following cycle: csec=0, sec=12, `o_tick`=1.
- Reset mid-operation: assert `rst` while `tick_pending`=1.
  - After release, no deferred tick is applied and outputs return to reset values.

Source files
------------

// File: rtl/watch_dp.sv
// watch_dp: hh:mm:ss.cc timekeeping datapath with field adjust.
// Optional WATCH_ADJ_CARRY_EN: adjusts carry/borrow into higher fields.
module watch_dp #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int HOUR_INIT = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel_pos,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [6:0] o_csec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_tick
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

`ifdef WATCH_ADJ_CARRY_EN
  localparam bit ADJ_CARRY = 1'b1;
`else
  localparam bit ADJ_CARRY = 1'b0;
`endif

  logic [DW-1:0] div_cnt;
  logic          tick_pending;

  logic tick_evt;
  logic adj;
  logic do_tick;

  logic [6:0] n_csec;
  logic [5:0] n_sec;
  logic [5:0] n_min;
  logic [4:0] n_hour;
  logic s_up, s_dn, m_up, m_dn, h_up, h_dn;
  logic carry_ok;

  assign tick_evt = (div_cnt == DIV_MAX);
  assign adj      = (i_inc ^ i_dec) && (sel_pos != 2'd3);
  assign do_tick  = (tick_evt || tick_pending) && !adj;
  // Ticks always ripple upward; adjusts only when carry is built in.
  assign carry_ok = do_tick || ADJ_CARRY;

  // Next-state of the time fields from a tick or an adjust.
  always_comb begin
    n_csec = o_csec;
    n_sec  = o_sec;
    n_min  = o_min;
    n_hour = o_hour;
    s_up = 1'b0;
    s_dn = 1'b0;
    m_up = 1'b0;
    m_dn = 1'b0;
    h_up = 1'b0;
    h_dn = 1'b0;
    if (do_tick) begin
      if (o_csec == 7'd99) begin
        n_csec = 7'd0;
        s_up   = 1'b1;
      end else begin
        n_csec = o_csec + 7'd1;
      end
    end
    if (adj) begin
      unique case (1'b1)
        sel_pos == 2'd0: begin
          s_up = i_inc;
          s_dn = i_dec;
        end
        sel_pos == 2'd1: begin
          m_up = i_inc;
          m_dn = i_dec;
        end
        sel_pos == 2'd2: begin
          h_up = i_inc;
          h_dn = i_dec;
        end
        default: ;
      endcase
    end
    if (s_up) begin
      if (o_sec == 6'd59) begin
        n_sec = 6'd0;
        if (carry_ok) m_up = 1'b1;
      end else begin
        n_sec = o_sec + 6'd1;
      end
    end
    if (s_dn) begin
      if (o_sec == 6'd0) begin
        n_sec = 6'd59;
        if (carry_ok) m_dn = 1'b1;
      end else begin
        n_sec = o_sec - 6'd1;
      end
    end
    if (m_up) begin
      if (o_min == 6'd59) begin
        n_min = 6'd0;
        if (carry_ok) h_up = 1'b1;
      end else begin
        n_min = o_min + 6'd1;
      end
    end
    if (m_dn) begin
      if (o_min == 6'd0) begin
        n_min = 6'd59;
        if (carry_ok) h_dn = 1'b1;
      end else begin
        n_min = o_min - 6'd1;
      end
    end
    if (h_up) begin
      n_hour = (o_hour == 5'd23) ? 5'd0 : o_hour + 5'd1;
    end
    if (h_dn) begin
      n_hour = (o_hour == 5'd0) ? 5'd23 : o_hour - 5'd1;
    end
  end

  // Prescaler, tick deferral and registered time fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      tick_pending <= 1'b0;
      o_csec       <= 7'd0;
      o_sec        <= 6'd0;
      o_min        <= 6'd0;
      o_hour       <= 5'(HOUR_INIT);
      o_tick       <= 1'b0;
    end else begin
      div_cnt      <= tick_evt ? '0 : div_cnt + 1'b1;
      tick_pending <= adj && (tick_evt || tick_pending);
      o_csec       <= n_csec;
      o_sec        <= n_sec;
      o_min        <= n_min;
      o_hour       <= n_hour;
      o_tick       <= do_tick;
    end
  end

endmodule

// File: tb/tb_watch_dp.sv
// tb_watch_dp: directed + random checks of watch_dp
// against a time-of-day reference model in hundredths.
module tb_watch_dp;

  localparam int TD  = 4;
  localparam int HI  = 12;
  localparam int DAY = 8640000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel_pos;
  logic       i_inc;
  logic       i_dec;
  logic [6:0] o_csec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;

  int total = 0;
  int bad   = 0;

  int mt;
  int mdiv;
  bit mpend;
  bit mtick;

  watch_dp #(
    .TICK_DIV (TD),
    .HOUR_INIT(HI)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel_pos(sel_pos),
    .i_inc  (i_inc),
    .i_dec  (i_dec),
    .o_csec (o_csec),
    .o_sec  (o_sec),
    .o_min  (o_min),
    .o_hour (o_hour),
    .o_tick (o_tick)
  );

  always #5 clk = ~clk;

  function automatic int m_cs();
    return mt % 100;
  endfunction
  function automatic int m_s();
    return (mt / 100) % 60;
  endfunction
  function automatic int m_m();
    return (mt / 6000) % 60;
  endfunction
  function automatic int m_h();
    return mt / 360000;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic apply_adj();
    int d;
    int h, m, s, cs;
    d = i_inc ? 1 : -1;
`ifdef WATCH_ADJ_CARRY_EN
    begin
      int step;
      step = (sel_pos == 2'd0) ? 100 :
             (sel_pos == 2'd1) ? 6000 : 360000;
      mt = ((mt + d * step) % DAY + DAY) % DAY;
    end
`else
    h  = m_h();
    m  = m_m();
    s  = m_s();
    cs = m_cs();
    case (sel_pos)
      2'd0:    s = (s + d + 60) % 60;
      2'd1:    m = (m + d + 60) % 60;
      default: h = (h + d + 24) % 24;
    endcase
    mt = h * 360000 + m * 6000 + s * 100 + cs;
`endif
  endtask

  task automatic model_edge();
    bit fire;
    bit adj;
    if (rst) begin
      mt    = HI * 360000;
      mdiv  = 0;
      mpend = 0;
      mtick = 0;
    end else begin
      fire = (mdiv == TD - 1);
      mdiv = (mdiv + 1) % TD;
      adj  = (i_inc ^ i_dec) && (sel_pos != 2'd3);
      if (adj) begin
        apply_adj();
        mpend = mpend | fire;
        mtick = 0;
      end else if (fire || mpend) begin
        mt    = (mt + 1) % DAY;
        mtick = 1;
        mpend = 0;
      end else begin
        mtick = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("csec", o_csec, m_cs());
    chk("sec",  o_sec,  m_s());
    chk("min",  o_min,  m_m());
    chk("hour", o_hour, m_h());
    chk("tick", o_tick, mtick);
  endtask

  task automatic drive(input logic [1:0] s,
                       input logic inc,
                       input logic dec);
    sel_pos = s;
    i_inc   = inc;
    i_dec   = dec;
  endtask

  task automatic pulse(input logic [1:0] s,
                       input logic inc,
                       input logic dec);
    drive(s, inc, dec);
    cycle();
    drive(2'd3, 1'b0, 1'b0);
    cycle();
  endtask

  initial begin
    int k;
    int h0;
    int m0;
    rst = 1'b1;
    drive(2'd3, 1'b0, 1'b0);
    mt = 0; mdiv = 0; mpend = 0; mtick = 0;
    cycle();
    cycle();
    chk("rst_hour", o_hour, 12);
    chk("rst_min",  o_min,  0);
    chk("rst_sec",  o_sec,  0);
    chk("rst_csec", o_csec, 0);
    chk("rst_tick", o_tick, 0);
    rst = 1'b0;
    k = 0;
    do begin cycle(); k++; end while (!o_tick && k < 10);
    chk("first_tick_lat", k, 4);

    // preload 23:59:59
    k = 0;
    while (m_s() != 59 && k < 70) begin pulse(2'd0, 1'b0, 1'b1); k++; end
    k = 0;
    while (m_m() != 59 && k < 70) begin pulse(2'd1, 1'b0, 1'b1); k++; end
    k = 0;
    while (m_h() != 23 && k < 30) begin pulse(2'd2, 1'b1, 1'b0); k++; end
    k = 0;
    while (mt != DAY - 1 && k < 1000) begin cycle(); k++; end
    chk("reach_235959_99", mt, DAY - 1);
    k = 0;
    do begin cycle(); k++; end while (!mtick && k < 10);
    chk("roll_hour", o_hour, 0);
    chk("roll_min",  o_min,  0);
    chk("roll_sec",  o_sec,  0);
    chk("roll_csec", o_csec, 0);
    chk("roll_tick", o_tick, 1);

    // min 59 inc wrap
    k = 0;
    while (m_m() != 59 && k < 70) begin pulse(2'd1, 1'b0, 1'b1); k++; end
    h0 = m_h();
    drive(2'd1, 1'b1, 1'b0);
    cycle();
    drive(2'd3, 1'b0, 1'b0);
    chk("min_wrap", o_min, 0);
`ifdef WATCH_ADJ_CARRY_EN
    chk("min_wrap_hour", o_hour, (h0 + 1) % 24);
`else
    chk("min_wrap_hour", o_hour, h0);
`endif
    cycle();

    // sec 0 dec wrap
    k = 0;
    while (m_s() != 0 && k < 70) begin pulse(2'd0, 1'b1, 1'b0); k++; end
    m0 = m_m();
    drive(2'd0, 1'b0, 1'b1);
    cycle();
    drive(2'd3, 1'b0, 1'b0);
    chk("sec_wrap", o_sec, 59);
`ifdef WATCH_ADJ_CARRY_EN
    chk("sec_wrap_min", o_min, (m0 + 59) % 60);
`else
    chk("sec_wrap_min", o_min, m0);
`endif
    cycle();

    // ignored adjusts
    h0 = m_h();
    m0 = m_m();
    drive(2'd3, 1'b1, 1'b0);
    cycle();
    chk("ign_sel3_min", o_min, m0);
    drive(2'd2, 1'b1, 1'b1);
    cycle();
    drive(2'd3, 1'b0, 1'b0);
    chk("ign_both_hour", o_hour, h0);
    cycle();

    // collision: sec=10, csec=99, inc on tick
    k = 0;
    while (m_cs() != 0 && k < 500) begin cycle(); k++; end
    k = 0;
    while (m_s() != 10 && k < 70) begin pulse(2'd0, 1'b1, 1'b0); k++; end
    k = 0;
    while (!(m_cs() == 99 && mdiv == TD - 1) && k < 500) begin
      cycle();
      k++;
    end
    chk("coll_setup_sec", o_sec, 10);
    drive(2'd0, 1'b1, 1'b0);
    cycle();
    drive(2'd3, 1'b0, 1'b0);
    chk("coll_sec1",  o_sec,  11);
    chk("coll_csec1", o_csec, 99);
    chk("coll_tick1", o_tick, 0);
    cycle();
    chk("coll_sec2",  o_sec,  12);
    chk("coll_csec2", o_csec, 0);
    chk("coll_tick2", o_tick, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      sel_pos = 2'($urandom_range(0, 3));
      i_inc   = ($urandom_range(0, 9) < 3);
      i_dec   = ($urandom_range(0, 9) < 3);
      cycle();
    end
    drive(2'd3, 1'b0, 1'b0);
    cycle();

    // reset while a tick is pending
    k = 0;
    while (mdiv != TD - 1 && k < 10) begin cycle(); k++; end
    drive(2'd0, 1'b1, 1'b0);
    cycle();
    chk("pend_set", mpend, 1);
    drive(2'd3, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst2_hour", o_hour, 12);
    chk("rst2_csec", o_csec, 0);
    chk("rst2_tick", o_tick, 0);
    k = 0;
    do begin cycle(); k++; end while (!o_tick && k < 10);
    chk("rst2_tick_lat", k, 4);
    chk("rst2_csec1", o_csec, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
